// File: rtl/s_seq_restoring_div4_if.sv
// -----------------------------------------------------------------------------
// s_seq_restoring_div4_if
// Handshake bundle for the sequential signed restoring divider.
//
// Signals:
//   in_valid  : producer has operands on a/b
//   in_ready  : divider can accept (idle)
//   a         : 2N-bit signed dividend
//   b         : N-bit signed divisor
//   out_valid : q/r/ovf/div0 hold a result, stays high until taken
//   out_ready : consumer takes the result
//   q, r      : N-bit signed quotient / remainder
//   ovf       : quotient does not fit in N signed bits
//   div0      : divisor was zero
//
// Modports: master = producer/consumer side, slave = divider side.
// -----------------------------------------------------------------------------
interface s_seq_restoring_div4_if #(
    parameter int N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           ovf;
    logic           div0;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, r, ovf, div0
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, r, ovf, div0
    );
endinterface

// File: rtl/s_seq_restoring_div4.sv
// -----------------------------------------------------------------------------
// s_seq_restoring_div4
// Sequential signed divider: 2N-bit dividend / N-bit divisor, radix-2
// restoring iteration on magnitudes, signs applied in a final fix-up cycle.
// Quotient truncates toward zero, remainder takes the dividend's sign.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : slave side of s_seq_restoring_div4_if (valid/ready in and out)
//
// Latency from the accept cycle to out_valid: 2N+2 cycles, 1 cycle when the
// divisor is zero.
// -----------------------------------------------------------------------------
module s_seq_restoring_div4 #(
    parameter int N = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    s_seq_restoring_div4_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(2*N);
    localparam logic [CW-1:0]  LAST_STEP = CW'(2*N-1);
    localparam logic [2*N-1:0] QPOS_MAX  = (2*N)'(2**(N-1) - 1);
    localparam logic [2*N-1:0] QNEG_MAX  = (2*N)'(2**(N-1));

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] dvd_sh;
    logic [2*N-1:0] quo;
    logic [N-1:0]   dvs_mag;
    logic [N:0]     rem;
    logic           sign_q;
    logic           sign_r;
    logic [N-1:0]   q_reg;
    logic [N-1:0]   r_reg;
    logic           ovf_reg;
    logic           div0_reg;

    logic           accept;
    logic [2*N-1:0] a_mag;
    logic [N-1:0]   b_mag;
    logic [N+1:0]   rem_shift;
    logic [N+1:0]   trial;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;
    logic           q_ovf;

    assign accept = (state == IDLE) && bus.in_valid;

    // State register; reset drops straight back to IDLE so a partially
    // computed result can never surface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DONE ignores in_valid, so a result and a new accept
    // never overlap; CALC leaves after the last of the 2N restoring steps.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid) state_next = (bus.b == '0) ? DONE : CALC;
            CALC: if (cnt == LAST_STEP) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Combinational datapath: operand magnitudes, one trial subtraction and
    // the sign fix-up. The most negative dividend has a magnitude of 2^(2N-1),
    // which still fits the 2N-bit unsigned register. Only the low N bits of
    // the signed quotient are kept, and those equal the low bits of the
    // negated magnitude, so the negation is done on N bits. The remainder
    // magnitude is always below |b| <= 2^(N-1), so its low N bits are exact.
    always_comb begin
        a_mag     = bus.a[2*N-1] ? -bus.a : bus.a;
        b_mag     = bus.b[N-1]   ? -bus.b : bus.b;
        rem_shift = {rem, dvd_sh[2*N-1]};
        trial     = rem_shift - {2'b00, dvs_mag};
        q_fix     = sign_q ? -quo[N-1:0] : quo[N-1:0];
        r_fix     = sign_r ? -rem[N-1:0] : rem[N-1:0];
        q_ovf     = sign_q ? (quo > QNEG_MAX) : (quo > QPOS_MAX);
    end

    // Datapath registers. IDLE latches magnitudes/signs (or writes the
    // divide-by-zero result directly), CALC runs one restoring step per
    // cycle MSB first, FIX applies signs and writes the visible result.
    // The visible result stays put after the handshake until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            dvd_sh   <= '0;
            quo      <= '0;
            dvs_mag  <= '0;
            rem      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            q_reg    <= '0;
            r_reg    <= '0;
            ovf_reg  <= 1'b0;
            div0_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.b == '0) begin
                            q_reg    <= '1;
                            r_reg    <= bus.a[N-1:0];
                            div0_reg <= 1'b1;
                            ovf_reg  <= 1'b0;
                        end else begin
                            dvd_sh  <= a_mag;
                            dvs_mag <= b_mag;
                            sign_q  <= bus.a[2*N-1] ^ bus.b[N-1];
                            sign_r  <= bus.a[2*N-1];
                            rem     <= '0;
                            quo     <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                CALC: begin
                    dvd_sh <= {dvd_sh[2*N-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (!trial[N+1]) begin
                        rem <= trial[N:0];
                        quo <= {quo[2*N-2:0], 1'b1};
                    end else begin
                        rem <= rem_shift[N:0];
                        quo <= {quo[2*N-2:0], 1'b0};
                    end
                end
                FIX: begin
                    q_reg    <= q_fix;
                    r_reg    <= r_fix;
                    ovf_reg  <= q_ovf;
                    div0_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.q         = q_reg;
    assign bus.r         = r_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.div0      = div0_reg;

endmodule

// File: tb/tb_s_seq_restoring_div4.sv
// -----------------------------------------------------------------------------
// tb_s_seq_restoring_div4
// Self-checking bench for s_seq_restoring_div4 (N=4). Expected results are
// pushed into a scoreboard queue when operands are accepted and popped when
// out_valid appears. Vectors come from a constant table, a reference model
// built on the simulator's signed / and %, and hand-written sequences for
// output back-pressure and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_s_seq_restoring_div4;

    localparam int N = 4;

    typedef struct {
        logic [2*N-1:0] a;
        logic [N-1:0]   b;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           ovf;
        logic           div0;
        int             lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t sb[$];
    vec_t table_v[15];

    s_seq_restoring_div4_if #(.N(N)) bus ();

    s_seq_restoring_div4 #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports a mismatch.
    task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: signed division truncating toward zero.
    function automatic vec_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
        vec_t v;
        int   qi;
        int   ri;
        v.a = a;
        v.b = b;
        if (b == '0) begin
            v.q    = '1;
            v.r    = a[N-1:0];
            v.ovf  = 1'b0;
            v.div0 = 1'b1;
            v.lat  = 1;
        end else begin
            qi     = int'($signed(a)) / int'($signed(b));
            ri     = int'($signed(a)) % int'($signed(b));
            v.q    = qi[N-1:0];
            v.r    = ri[N-1:0];
            v.ovf  = (qi > 7) || (qi < -8);
            v.div0 = 1'b0;
            v.lat  = 2*N + 2;
        end
        return v;
    endfunction

    // Present one operand pair for exactly one accept edge and record the
    // expected result.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        compare("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        sb.push_back(v);
    endtask

    // Wait (bounded) for out_valid, compare against the scoreboard head and,
    // if take is set, complete the output handshake.
    task automatic checkOutput(input bit take);
        vec_t e;
        bit   seen;
        int   lat;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        compare("out_valid_seen", 32'(seen), 32'd1);
        if (seen) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got unexpected result q=0x%0h, expected no result", bus.q);
            end else begin
                e = sb.pop_front();
                compare($sformatf("latency a=%0h b=%0h", e.a, e.b), 32'(lat), 32'(e.lat));
                compare($sformatf("q a=%0h b=%0h", e.a, e.b), 32'(bus.q), 32'(e.q));
                compare($sformatf("r a=%0h b=%0h", e.a, e.b), 32'(bus.r), 32'(e.r));
                compare($sformatf("ovf a=%0h b=%0h", e.a, e.b), 32'(bus.ovf), 32'(e.ovf));
                compare($sformatf("div0 a=%0h b=%0h", e.a, e.b), 32'(bus.div0), 32'(e.div0));
                compare("in_ready_while_done", 32'(bus.in_ready), 32'd0);
                if (take) begin
                    bus.out_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'b0;
                    @(negedge clk);
                    compare("out_valid_after_take", 32'(bus.out_valid), 32'd0);
                    compare("in_ready_after_take", 32'(bus.in_ready), 32'd1);
                    compare("q_held_after_take", 32'(bus.q), 32'(e.q));
                end
            end
        end
    endtask

    initial begin
        vec_t v;
        vec_t v2;
        int   stray;

        checks = 0;
        errors = 0;

        // a, b, q, r, ovf, div0, latency
        table_v[0]  = '{8'hD6, 4'h5, 4'h8, 4'hE, 1'b0, 1'b0, 10};
        table_v[1]  = '{8'h2A, 4'hA, 4'h9, 4'h0, 1'b0, 1'b0, 10};
        table_v[2]  = '{8'hF9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0, 10};
        table_v[3]  = '{8'h80, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0, 10};
        table_v[4]  = '{8'hC0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0, 10};
        table_v[5]  = '{8'h20, 4'hC, 4'h8, 4'h0, 1'b0, 1'b0, 10};
        table_v[6]  = '{8'h37, 4'h0, 4'hF, 4'h7, 1'b0, 1'b1, 1};
        table_v[7]  = '{8'h7F, 4'h7, 4'h2, 4'h1, 1'b1, 1'b0, 10};
        table_v[8]  = '{8'h80, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0, 10};
        table_v[9]  = '{8'hF8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0, 10};
        table_v[10] = '{8'h07, 4'h1, 4'h7, 4'h0, 1'b0, 1'b0, 10};
        table_v[11] = '{8'h08, 4'h1, 4'h8, 4'h0, 1'b1, 1'b0, 10};
        table_v[12] = '{8'hF9, 4'hD, 4'h2, 4'hF, 1'b0, 1'b0, 10};
        table_v[13] = '{8'h80, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 1};
        table_v[14] = '{8'h00, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 10};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b0;

        // Reset state
        #12;
        compare("reset_in_ready", 32'(bus.in_ready), 32'd1);
        compare("reset_out_valid", 32'(bus.out_valid), 32'd0);
        compare("reset_q", 32'(bus.q), 32'd0);
        compare("reset_r", 32'(bus.r), 32'd0);
        compare("reset_ovf", 32'(bus.ovf), 32'd0);
        compare("reset_div0", 32'(bus.div0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            applyStimulus(table_v[i]);
            checkOutput(1'b1);
        end

        // Random vectors against the reference model
        for (int i = 0; i < 16; i++) begin
            v = model(8'($urandom), 4'($urandom_range(0, 15)));
            applyStimulus(v);
            checkOutput(1'b1);
        end

        // Back-pressure: result held while new operands wait on in_valid
        v  = '{8'h15, 4'h4, 4'h5, 4'h1, 1'b0, 1'b0, 10};
        v2 = '{8'h0E, 4'h3, 4'h4, 4'h2, 1'b0, 1'b0, 10};
        applyStimulus(v);
        checkOutput(1'b0);
        bus.in_valid = 1'b1;
        bus.a        = v2.a;
        bus.b        = v2.b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compare("hold_out_valid", 32'(bus.out_valid), 32'd1);
            compare("hold_in_ready", 32'(bus.in_ready), 32'd0);
            compare("hold_q", 32'(bus.q), 32'(v.q));
            compare("hold_r", 32'(bus.r), 32'(v.r));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        compare("release_out_valid", 32'(bus.out_valid), 32'd0);
        compare("release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        sb.push_back(v2);
        checkOutput(1'b1);

        // Reset during the third CALC cycle aborts the operation
        v = '{8'h6B, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 10};
        applyStimulus(v);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compare("abort_out_valid", 32'(bus.out_valid), 32'd0);
        compare("abort_in_ready", 32'(bus.in_ready), 32'd1);
        compare("abort_q_cleared", 32'(bus.q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        stray = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        compare("abort_no_result", 32'(stray), 32'd0);
        v = '{8'h07, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0, 10};
        applyStimulus(v);
        checkOutput(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/s_seq_restoring_div4.md
Name: s_seq_restoring_div4

Overview:
- Sequential signed divider; the inverse operation of the team's 4x4 signed array/Wallace multipliers.
- Divides a 2N-bit two's-complement dividend (a product-width value) by an N-bit signed divisor.
- Returns an N-bit quotient (truncated toward zero) and an N-bit remainder that takes the dividend's sign.
- Uses a radix-2 restoring iteration over magnitudes, with valid/ready handshakes on both the input and output sides.

Parameters:
- N, 4, operand width; the dividend is 2N bits, divisor/quotient/remainder are N bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept; high only in IDLE
- a  input  2N  signed dividend
- b  input  N  signed divisor
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  consumer takes result
- q  output  N  signed quotient
- r  output  N  signed remainder
- ovf  output  1  quotient not representable in N signed bits
- div0  output  1  divisor was zero

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, q=0, r=0, ovf=0, div0=0, out_valid=0, in_ready=1.
  - Reset during any state aborts the operation immediately; no partial result is ever presented.
- States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE).
- IDLE:
  - Accept on an edge with in_valid=1 and in_ready=1.
  - If b==0: go to DONE. Register q={N{1}}, r=a[N-1:0], div0=1, ovf=0.
  - Otherwise latch |a| (2N bits unsigned; |-2^(2N-1)| = 2^(2N-1) fits), |b| (N bits unsigned), sign_q=a[2N-1]^b[N-1], sign_r=a[2N-1]. Clear the partial remainder (N+1 bits) and cnt=0. Go to CALC.
- CALC: one restoring step per cycle, MSB first, 2N cycles total.
  - Shift the next dividend bit into the partial remainder.
  - Trial-subtract |b|. If the result is non-negative, keep it and shift 1 into the quotient register (2N bits); otherwise restore and shift 0.
  - After step cnt==2N-1, go to FIX.
- FIX: one cycle.
  - Apply signs: Q=sign_q ? -Qmag : Qmag; R=sign_r ? -Rmag : Rmag.
  - ovf=1 iff Q lies outside [-2^(N-1), 2^(N-1)-1]. Evaluate this on the magnitude: Qmag > 2^(N-1)-1 when positive, Qmag > 2^(N-1) when negative.
  - q=Q[N-1:0] (wraps on overflow), r=R[N-1:0], div0=0. Go to DONE.
  - r is always exact because |R| < |b| <= 2^(N-1).
- DONE:
  - out_valid=1; q/r/ovf/div0 held stable; in_valid is ignored.
  - On an edge with out_ready=1: out_valid->0, go to IDLE.
  - q/r/ovf/div0 keep their values after the handshake until the next result is written.
- Latency, counted from the accept cycle to the first out_valid cycle:
  - Normal path: 2N+2 cycles (10 for N=4).
  - div0 path: 1 cycle.
  - Throughput: at most one operation per 2N+3 cycles; DONE and IDLE never overlap.
- out_ready asserted before out_valid has no effect.
- in_valid may drop at any time without effect unless accepted.

Test Plan:
- a=0xD6 (-42), b=0x5 -> out_valid 10 cycles after accept; q=0x8 (-8), r=0xE (-2), ovf=0, div0=0.
- a=0x2A (42), b=0xA (-6) -> q=0x9 (-7), r=0x0; then a=0xF9 (-7), b=0x2 -> q=0xD (-3), r=0xF (-1).
- a=0x80 (-128), b=0x8 (-8) -> quotient 16: ovf=1, q=0x0, r=0x0. Also a=0xC0 (-64), b=0x8 (-8) -> quotient 8: ovf=1, q=0x8. And a=0x20 (32), b=0xC (-4) -> quotient -8: ovf=0, q=0x8.
- a=0x37, b=0x0 -> out_valid on the cycle after accept; div0=1, q=0xF, r=0x7, ovf=0.
- Hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new operands -> q/r held, in_ready=0, no accept. Raise out_ready -> next cycle out_valid=0, in_ready=1, pending operands accepted.
- Pulse rst_n low during the 3rd CALC cycle -> out_valid=0 and in_ready=1 asynchronously; no result appears. Then a=0x07, b=0x2 -> q=0x3, r=0x1 after 10 cycles.
